// File: rtl/backward.sv
// Hidden-to-visible reconstruction: for each visible unit i, accumulates
// h[j]*W[j][i] over all hidden units through a two-stage pipeline, then saturates.
module backward #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 32,
  parameter int N_HID     = 16,
  parameter int N_VIS     = 784,
  localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1,
  localparam int AW = (N_HID * N_VIS > 1) ? $clog2(N_HID * N_VIS) : 1,
  localparam int VW = (N_VIS > 1) ? $clog2(N_VIS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hid_wr_en,
  input  logic [HW-1:0]        hid_wr_addr,
  input  logic [WIDTH_IN-1:0]  hid_wr_data,
  output logic                 w_rd_en,
  output logic [AW-1:0]        w_rd_addr,
  input  logic [WIDTH_IN-1:0]  w_rd_data,
  output logic                 vis_valid,
  output logic [VW-1:0]        vis_addr,
  output logic [WIDTH_OUT-1:0] vis_data,
  output logic                 busy,
  output logic                 done
);

  localparam int PW   = 2 * WIDTH_IN;
  localparam int ACCW = WIDTH_OUT + 8;
  localparam logic [HW-1:0] J_LAST   = HW'(N_HID - 1);
  localparam logic [VW-1:0] I_LAST   = VW'(N_VIS - 1);
  localparam logic [AW-1:0] ADDR_STEP = AW'(N_VIS);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           i_q, i_d;
  logic [HW-1:0]           j_q, j_d;
  logic [HW-1:0]           jd_q, jd_d;
  logic                    drain_q, drain_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]           w_rd_addr_q, w_rd_addr_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [ACCW-1:0]  acc_sum;
  logic [ACCW-WIDTH_OUT:0] acc_top;
  logic                    acc_ovf;
  logic [WIDTH_OUT-1:0]    sat_val;
  logic                    vis_valid_q, vis_valid_d;
  logic [VW-1:0]           vis_addr_q, vis_addr_d;
  logic [WIDTH_OUT-1:0]    vis_data_q, vis_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH_IN-1:0]     hid_q [N_HID];
  logic                    hid_we;

  assign hid_we = hid_wr_en && (state_q == S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N_HID; gi++) begin : g_hid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hid_q[gi] <= '0;
        end else if (hid_we && (hid_wr_addr == HW'(gi))) begin
          hid_q[gi] <= hid_wr_data;
        end
      end
    end
  endgenerate

  // Saturate when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    acc_sum = acc_q + {{(ACCW - PW){p_q[PW-1]}}, p_q};
    acc_top = acc_sum[ACCW-1:WIDTH_OUT-1];
    acc_ovf = !((&acc_top) || !(|acc_top));
    if (!acc_ovf)
      sat_val = acc_sum[WIDTH_OUT-1:0];
    else if (acc_sum[ACCW-1])
      sat_val = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    else
      sat_val = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    drain_d     = drain_q;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = w_rd_addr_q;
    vis_valid_d = 1'b0;
    vis_addr_d  = vis_addr_q;
    vis_data_d  = vis_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_vld_d    = w_rd_en_q;
    jd_d        = j_q;
    p_d         = rd_vld_q ? PW'($signed(hid_q[jd_q])) * PW'($signed(w_rd_data)) : '0;
    acc_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          i_d         = '0;
          j_d         = '0;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = '0;
          busy_d      = 1'b1;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          j_d         = j_q + 1'b1;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = w_rd_addr_q + ADDR_STEP;
        end
      end
      S_DRAIN: begin
        acc_d = acc_sum;
        if (drain_q) begin
          state_d     = S_OUT;
          vis_valid_d = 1'b1;
          vis_addr_d  = i_q;
          vis_data_d  = sat_val;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_OUT: begin
        j_d = '0;
        if (i_q == I_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          i_d         = i_q + 1'b1;
          state_d     = S_RUN;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = AW'(i_q) + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      jd_q        <= '0;
      drain_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      w_rd_en_q   <= 1'b0;
      w_rd_addr_q <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      vis_valid_q <= 1'b0;
      vis_addr_q  <= '0;
      vis_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      jd_q        <= jd_d;
      drain_q     <= drain_d;
      rd_vld_q    <= rd_vld_d;
      w_rd_en_q   <= w_rd_en_d;
      w_rd_addr_q <= w_rd_addr_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      vis_valid_q <= vis_valid_d;
      vis_addr_q  <= vis_addr_d;
      vis_data_q  <= vis_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign w_rd_en   = w_rd_en_q;
  assign w_rd_addr = w_rd_addr_q;
  assign vis_valid = vis_valid_q;
  assign vis_addr  = vis_addr_q;
  assign vis_data  = vis_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_backward.sv
// Scoreboard bench for backward with N_HID=4, N_VIS=3 and a registered weight memory model.
module tb_backward;
  localparam int NH = 4;
  localparam int NV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hid_wr_en = 1'b0;
  logic [1:0]  hid_wr_addr = '0;
  logic [15:0] hid_wr_data = '0;
  logic        w_rd_en;
  logic [3:0]  w_rd_addr;
  logic [15:0] w_rd_data = '0;
  logic        vis_valid;
  logic [1:0]  vis_addr;
  logic [31:0] vis_data;
  logic        busy;
  logic        done;

  backward #(.WIDTH_IN(16), .WIDTH_OUT(32), .N_HID(NH), .N_VIS(NV)) dut (
    .clk(clk), .rst(rst), .start(start),
    .hid_wr_en(hid_wr_en), .hid_wr_addr(hid_wr_addr), .hid_wr_data(hid_wr_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .vis_valid(vis_valid), .vis_addr(vis_addr), .vis_data(vis_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] wmem [NH*NV];
  always @(posedge clk) if (w_rd_en) w_rd_data <= wmem[w_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int dones = 0, start_cyc = 0, last_vis_cyc = 0, vis_in_run = 0;
  bit done_prev = 1'b0;
  logic [33:0] vis_q [$];
  logic [3:0]  addr_q [$];
  logic [1:0]  ea;
  logic [31:0] ed;
  logic [3:0]  seq [12] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd1, 4'd4, 4'd7, 4'd10, 4'd2, 4'd5, 4'd8, 4'd11};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a visible result.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_rd_en) begin
        if (addr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_unexpected: got addr %0d expected no read", w_rd_addr);
        end else check("w_rd_addr", {28'd0, w_rd_addr}, {28'd0, addr_q.pop_front()});
      end
      if (vis_valid) begin
        if (vis_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL vis_unexpected: got addr %0d data %h expected no strobe", vis_addr, vis_data);
        end else begin
          {ea, ed} = vis_q.pop_front();
          check("vis_addr", {30'd0, vis_addr}, {30'd0, ea});
          check("vis_data", vis_data, ed);
          if (vis_in_run == 0) check("vis_first_lat", cyc - start_cyc, 6);
          else                 check("vis_spacing", cyc - last_vis_cyc, 7);
          check("busy_in_run", {31'd0, busy}, 1);
        end
        last_vis_cyc = cyc;
        vis_in_run++;
      end
      if (done) begin
        dones++;
        check("done_timing", cyc - last_vis_cyc, 1);
      end
      if (done_prev) check("busy_after_done", {31'd0, busy}, 0);
      done_prev = done;
    end
  end

  task automatic wr_hid(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    hid_wr_en = 1'b1; hid_wr_addr = a; hid_wr_data = d;
    @(negedge clk);
    hid_wr_en = 1'b0;
  endtask

  task automatic set_col(input int i, input logic [15:0] w0, w1, w2, w3);
    wmem[0*NV+i] = w0; wmem[1*NV+i] = w1; wmem[2*NV+i] = w2; wmem[3*NV+i] = w3;
  endtask

  task automatic push_run(input logic [31:0] e0, e1, e2);
    vis_q.push_back({2'd0, e0});
    vis_q.push_back({2'd1, e1});
    vis_q.push_back({2'd2, e2});
    for (int k = 0; k < 12; k++) addr_q.push_back(seq[k]);
  endtask

  task automatic start_run(input bit with_wr, input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1;
    if (with_wr) begin hid_wr_en = 1'b1; hid_wr_addr = a; hid_wr_data = d; end
    @(negedge clk);
    start = 1'b0; hid_wr_en = 1'b0;
    start_cyc = cyc;
    vis_in_run = 0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 200 && dones < target; k++) @(negedge clk);
    check("done_count", dones, target);
    repeat (6) @(negedge clk);
    check("done_single", dones, target);
    check("vis_pending", vis_q.size(), 0);
    check("rd_pending", addr_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_vis_valid"}, {31'd0, vis_valid}, 0);
    check({tag, "_w_rd_en"}, {31'd0, w_rd_en}, 0);
    check({tag, "_w_rd_addr"}, {28'd0, w_rd_addr}, 0);
    check({tag, "_vis_addr"}, {30'd0, vis_addr}, 0);
    check({tag, "_vis_data"}, vis_data, 0);
  endtask

  initial begin
    for (int k = 0; k < NH*NV; k++) wmem[k] = 16'h4000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // 0.5*0.5 summed over four hidden units, all columns equal
    for (int j = 0; j < NH; j++) wr_hid(j[1:0], 16'h4000);
    push_run(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    start_run(1'b0, 2'd0, 16'h0);
    wait_done(1);

    // Write to h[0] and a start pulse while busy must both be ignored
    push_run(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    start_run(1'b0, 2'd0, 16'h0);
    repeat (2) @(negedge clk);
    start = 1'b1; hid_wr_en = 1'b1; hid_wr_addr = 2'd0; hid_wr_data = 16'h7FFF;
    @(negedge clk);
    start = 1'b0; hid_wr_en = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    push_run(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    start_run(1'b0, 2'd0, 16'h0);
    wait_done(3);

    // Mixed signs; h[3] written in the same cycle as start
    wr_hid(2'd0, 16'h7FFF); wr_hid(2'd1, 16'h8000); wr_hid(2'd2, 16'h0000); wr_hid(2'd3, 16'h0000);
    set_col(0, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    set_col(1, 16'h7FFF, 16'h7FFF, 16'h1234, 16'hC000);
    set_col(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    push_run(32'h0000_3FFF, 32'hEFFF_8001, 32'hFFFF_C001);
    start_run(1'b1, 2'd3, 16'h4000);
    wait_done(4);

    // Saturation; column 2 sums to exactly 2^31, one past the positive limit
    for (int j = 0; j < NH; j++) wr_hid(j[1:0], 16'h8000);
    set_col(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    set_col(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    set_col(2, 16'h8000, 16'h8000, 16'h0000, 16'h0000);
    push_run(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
    start_run(1'b0, 2'd0, 16'h0);
    wait_done(5);

    // Reset in the drain before the second visible strobe
    for (int k = 0; k < NH*NV; k++) wmem[k] = 16'h4000;
    for (int j = 0; j < NH; j++) wr_hid(j[1:0], 16'h4000);
    push_run(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    start_run(1'b0, 2'd0, 16'h0);
    for (int k = 0; k < 50 && vis_in_run < 1; k++) begin @(negedge clk); #1; end
    check("first_vis_seen", vis_in_run, 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrun");
    check("vis_left_at_abort", vis_q.size(), 2);
    check("rd_left_at_abort", addr_q.size(), 4);
    vis_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", dones, 5);
    check("idle_after_abort", {31'd0, busy}, 0);

    // Hidden buffer was cleared by reset
    push_run(32'h0, 32'h0, 32'h0);
    start_run(1'b0, 2'd0, 16'h0);
    wait_done(6);
    for (int j = 0; j < NH; j++) wr_hid(j[1:0], 16'h4000);
    push_run(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    start_run(1'b0, 2'd0, 16'h0);
    wait_done(7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/backward.md
BACKWARD -- requirements
Module: backward

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 16, meaning hidden-activation and weight width (signed Q1.15).
REQ-002 SHALL have parameter WIDTH_OUT, default 32, meaning reconstructed visible-sum width (signed).
REQ-003 SHALL have parameter N_HID, default 16, meaning number of hidden units summed per visible unit.
REQ-004 SHALL have parameter N_VIS, default 784, meaning number of visible units reconstructed per run.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a reconstruction run.
REQ-008 hid_wr_en  input  1  write strobe for the internal hidden-activation buffer.
REQ-009 hid_wr_addr  input  clog2(N_HID)  hidden buffer write index.
REQ-010 hid_wr_data  input  WIDTH_IN  hidden activation h[j].
REQ-011 w_rd_en  output  1  weight memory read strobe.
REQ-012 w_rd_addr  output  clog2(N_HID*N_VIS)  weight address, j*N_VIS+i.
REQ-013 w_rd_data  input  WIDTH_IN  weight W[j][i], valid one cycle after w_rd_en.
REQ-014 vis_valid  output  1  one-cycle strobe marking vis_addr/vis_data valid.
REQ-015 vis_addr  output  clog2(N_VIS)  visible index i of vis_data.
REQ-016 vis_data  output  WIDTH_OUT  saturated sum over j of h[j]*W[j][i].
REQ-017 busy  output  1  high from the cycle after accepted start until done.
REQ-018 done  output  1  one-cycle pulse at run completion.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, OUT, DONE.
REQ-020 IDLE: start=1 -> RUN next cycle; i=0, j=0, accumulator=0; start SHALL be ignored in every other state.
REQ-021 RUN: each cycle, w_rd_en=1, w_rd_addr=j*N_VIS+i; j increments; after j=N_HID-1 is issued -> DRAIN.
REQ-022 Pipeline: cycle t read issue; t+1 product register p = h[j]*W (signed 16x16 -> 32 bit); t+2 accumulator += sign-extended p.
REQ-023 DRAIN SHALL last exactly 2 cycles with w_rd_en=0 so the final product is accumulated, then -> OUT.
REQ-024 OUT: vis_valid=1 for one cycle, vis_addr=i, vis_data=saturate(acc); accumulator cleared; j=0; if i=N_VIS-1 -> DONE, else i+1 and -> RUN.
REQ-025 Per visible unit: exactly N_HID+3 cycles; total run N_VIS*(N_HID+3) cycles from first RUN cycle to last OUT cycle.
REQ-026 Accumulator SHALL be WIDTH_OUT+8 bits signed, no internal wrap for N_HID<=256.
REQ-027 Saturation: acc > 2^(WIDTH_OUT-1)-1 -> 0x7FFF_FFFF; acc < -2^(WIDTH_OUT-1) -> 0x8000_0000; otherwise low WIDTH_OUT bits.
REQ-028 DONE: done=1 for one cycle, busy=0 in the following cycle, -> IDLE.
REQ-029 hid_wr_en SHALL write the buffer only while IDLE; writes while busy SHALL be discarded.
REQ-030 hid_wr_en and start in the same IDLE cycle: write takes effect and run starts; the run SHALL use the newly written value.
REQ-031 vis_data/vis_addr SHALL hold their last values when vis_valid=0; no backpressure exists, the consumer must take every strobe.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, busy=0, done=0, vis_valid=0, w_rd_en=0, w_rd_addr=0, vis_addr=0, vis_data=0, accumulator=0, product register=0.
REQ-033 Hidden buffer SHALL be cleared to 0 by reset.
REQ-034 Reset mid-run SHALL abort with no further vis_valid or done; a new start after release SHALL run from i=0.

Verification (N_HID=4, N_VIS=3 unless stated)
REQ-035 h=all 0x4000, W=all 0x4000, start -> three vis_valid strobes, addr 0,1,2, each vis_data=0x4000_0000, spaced 7 cycles; done 1 cycle after third.
REQ-036 h={0x7FFF,0x8000,0,0x4000}, W[j][1]={0x7FFF,0x7FFF,0x1234,0xC000} -> vis_addr 1 data = 0x3FFF0001-0x3FFF8000+0-0x10000000 = 0xEFFF8001.
REQ-037 N_HID=16, h=all 0x8000, W=all 0x8000 -> every vis_data=0x7FFF_FFFF (positive saturation); h=0x8000, W=0x7FFF -> 0x8000_0000.
REQ-038 Check w_rd_addr sequence 0,3,6,9 | 1,4,7,10 | 2,5,8,11 and start pulses during busy ignored (single done only).
REQ-039 Assert rst during second OUT-preceding DRAIN -> outputs zero same cycle, no done; restart yields full correct 3-unit run.
REQ-040 hid_wr_en during busy to index 0 with 0x7FFF -> current and next run use old h[0].
